// File: rtl/mc_pkg.sv
// -----------------------------------------------------------------------------
// mc_pkg
// Shared definitions for the multicycle controller: state encoding, opcode and
// funct field values, ALU control codes and datapath mux select codes.
//
// Optional feature macro: MULTICYCLE_BNE_EN (consumed by multicycle_fsm; the
// BNEEX encoding is always reserved here so the state numbering is identical
// in both builds).
// -----------------------------------------------------------------------------
package mc_pkg;

    // Controller state; also exported on the 4-bit debug port.
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REX    = 4'd6,
        S_RWB    = 4'd7,
        S_BEQEX  = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JEX    = 4'd11,
        S_ERROR  = 4'd12,
        S_BNEEX  = 4'd13
    } state_t;

    // Opcode field, instruction bits [31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // Funct field, instruction bits [5:0] (R-type only)
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU control codes
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALU source B select
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    // PC source select
    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // States that wait on the unified memory and therefore run the timeout.
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mc_aludec.sv
// -----------------------------------------------------------------------------
// mc_aludec
// Combinational R-type funct decoder for the multicycle controller.
//
// Ports:
//   i_funct   in  6  instruction bits [5:0]
//   o_aluctrl out 3  ALU control code for the funct (0 when unsupported)
//   o_valid   out 1  funct is one of the supported R-type operations
// -----------------------------------------------------------------------------
module mc_aludec
    import mc_pkg::*;
(
    input  logic [5:0] i_funct,
    output logic [2:0] o_aluctrl,
    output logic       o_valid
);

    always_comb begin
        o_aluctrl = '0;
        o_valid   = 1'b1;
        case (i_funct)
            FN_ADD:  o_aluctrl = ALU_ADD;
            FN_SUB:  o_aluctrl = ALU_SUB;
            FN_AND:  o_aluctrl = ALU_AND;
            FN_OR:   o_aluctrl = ALU_OR;
            FN_SLT:  o_aluctrl = ALU_SLT;
            default: o_valid   = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_fsm
// Main controller for a multicycle MIPS-style datapath with a unified memory.
// Each memory state waits on mem_ready, bounded by MEM_TIMEOUT cycles; an
// expired wait, unknown opcode or unsupported funct parks the controller in a
// sticky ERROR state that only reset clears.
//
// Optional feature macro: MULTICYCLE_BNE_EN -- when defined, op 000101 (bne)
// executes in BNEEX; when undefined it is treated as an unknown opcode.
//
// Parameters:
//   MEM_TIMEOUT  max cycles spent waiting for mem_ready in one memory state
//
// Ports:
//   clk        in   1  clock, rising edge
//   rst        in   1  asynchronous active-high reset
//   op         in   6  instruction bits [31:26]
//   funct      in   6  instruction bits [5:0]
//   zero       in   1  ALU zero flag
//   mem_ready  in   1  memory completes the current access this cycle
//   iord, irwrite, memwrite, regdst, memtoreg, regwrite, alusrca, pcen
//              out  1  datapath controls
//   error      out  1  sticky fault flag (controller is in ERROR)
//   alusrcb    out  2  ALU source B select
//   pcsrc      out  2  PC source select
//   aluctrl    out  3  ALU operation
//   state      out  4  current state, for debug/display
// -----------------------------------------------------------------------------
module multicycle_fsm
    import mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic       pcen,
    output logic       error,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] aluctrl,
    output logic [3:0] state
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_TIMEOUT - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_wait;
    logic             w_mem_state;
    logic             w_timeout;
    logic [2:0]       w_funct_ctrl;
    logic             w_funct_ok;

    mc_aludec u_aludec (
        .i_funct   (funct),
        .o_aluctrl (w_funct_ctrl),
        .o_valid   (w_funct_ok)
    );

    assign w_mem_state = is_mem_state(r_state);

    // r_wait counts the not-ready cycles already spent in this memory state.
    // The timeout fires on the MEM_TIMEOUT-th consecutive not-ready cycle;
    // a ready cycle always completes the access, so a late completion beats
    // the timeout.
    assign w_timeout = w_mem_state && !mem_ready && (r_wait == LAST_WAIT);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (mem_ready)      w_next = S_DECODE;
                else if (w_timeout) w_next = S_ERROR;
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_REX;
                    OP_BEQ:       w_next = S_BEQEX;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JEX;
`ifdef MULTICYCLE_BNE_EN
                    OP_BNE:       w_next = S_BNEEX;
`endif
                    default:      w_next = S_ERROR;
                endcase
            end
            S_MEMADR: w_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (mem_ready)      w_next = S_MEMWB;
                else if (w_timeout) w_next = S_ERROR;
            end
            S_MEMWR: begin
                if (mem_ready)      w_next = S_FETCH;
                else if (w_timeout) w_next = S_ERROR;
            end
            S_REX:    w_next = w_funct_ok ? S_RWB : S_ERROR;
            S_ADDIEX: w_next = S_ADDIWB;
            S_MEMWB, S_RWB, S_BEQEX, S_ADDIWB, S_JEX:
                      w_next = S_FETCH;
`ifdef MULTICYCLE_BNE_EN
            S_BNEEX:  w_next = S_FETCH;
`endif
            S_ERROR:  w_next = S_ERROR;
            default:  w_next = S_ERROR;
        endcase
    end

    // ------------------------------------------------------------------
    // State and wait counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_wait  <= '0;
        end else begin
            r_state <= w_next;
            // Any state change is an entry into a fresh state, so clearing
            // on change covers entry into FETCH, MEMRD and MEMWR.
            if (w_next != r_state) begin
                r_wait <= '0;
            end else if (w_mem_state && !mem_ready) begin
                r_wait <= r_wait + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control outputs, decoded combinationally from the current state
    // ------------------------------------------------------------------
    always_comb begin
        iord     = 1'b0;
        irwrite  = 1'b0;
        memwrite = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        pcen     = 1'b0;
        error    = 1'b0;
        alusrcb  = SRCB_REG;
        pcsrc    = PC_ALU;
        aluctrl  = ALU_AND;

        case (r_state)
            S_FETCH: begin
                alusrcb = SRCB_FOUR;
                aluctrl = ALU_ADD;
                irwrite = mem_ready;
                pcen    = mem_ready;
            end
            S_DECODE: begin
                alusrcb = SRCB_BRANCH;
                aluctrl = ALU_ADD;
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                aluctrl = ALU_ADD;
            end
            S_MEMRD: begin
                iord = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = mem_ready;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            S_REX: begin
                alusrca = 1'b1;
                aluctrl = w_funct_ctrl;
            end
            S_RWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            S_BEQEX: begin
                alusrca = 1'b1;
                aluctrl = ALU_SUB;
                pcsrc   = PC_ALUOUT;
                pcen    = zero;
            end
`ifdef MULTICYCLE_BNE_EN
            S_BNEEX: begin
                alusrca = 1'b1;
                aluctrl = ALU_SUB;
                pcsrc   = PC_ALUOUT;
                pcen    = ~zero;
            end
`endif
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                aluctrl = ALU_ADD;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
            end
            S_JEX: begin
                pcsrc = PC_JUMP;
                pcen  = 1'b1;
            end
            S_ERROR: begin
                error = 1'b1;
            end
            default: begin
                error = 1'b1;
            end
        endcase

        // Reset already forces FETCH asynchronously; also mask the
        // mem_ready-driven enables of FETCH so nothing is written while
        // reset is held.
        if (rst) begin
            irwrite  = 1'b0;
            memwrite = 1'b0;
            regwrite = 1'b0;
            pcen     = 1'b0;
        end
    end

    assign state = r_state;

endmodule

// File: tb/tb_multicycle_fsm.sv
// -----------------------------------------------------------------------------
// tb_multicycle_fsm
// Scoreboard bench for multicycle_fsm. Stimulus walks whole instructions at
// instruction level (fetch, decode, execute steps, with chosen memory wait
// lengths) and pushes the outputs each cycle should show; a monitor on the
// falling edge pops and compares them against the DUT.
// Build with MULTICYCLE_BNE_EN defined to exercise the bne option.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_multicycle_fsm;
  import mc_pkg::*;

  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic       iord, irwrite, memwrite, regdst, memtoreg, regwrite;
  logic       alusrca, pcen, error;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] aluctrl;
  logic [3:0] state;

  multicycle_fsm #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .iord(iord), .irwrite(irwrite),
    .memwrite(memwrite), .regdst(regdst), .memtoreg(memtoreg),
    .regwrite(regwrite), .alusrca(alusrca), .pcen(pcen), .error(error),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .aluctrl(aluctrl), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       iord, irwrite, memwrite, regdst, memtoreg, regwrite;
    logic       alusrca, pcen, error;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] aluctrl;
    logic [3:0] st;
  } obs_t;

  typedef struct {
    obs_t  v;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   cyc_no = 0;
  int   z_force = -1;   // -1: random zero flag, else forced value

  // Supported R-type functs and their ALU codes, straight from the table.
  function automatic logic [2:0] alu_of(input logic [5:0] fn);
    logic [5:0] fns [5]   = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] codes [5] = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111};
    alu_of = 3'b000;
    for (int unsigned i = 0; i < 5; i++) if (fns[i] == fn) alu_of = codes[i];
  endfunction

  function automatic bit funct_ok(input logic [5:0] fn);
    return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  endfunction

  // What the controls must read in a cycle spent in step s.
  function automatic obs_t ctl_of(input state_t s, input logic mr, input logic z,
                                  input logic [5:0] fn, input logic r);
    obs_t   o;
    state_t t;
    o = '0;
    t = r ? S_FETCH : s;
    o.st = t;
    case (t)
      S_FETCH:  begin o.alusrcb = 2'b01; o.aluctrl = 3'b010;
                      o.irwrite = mr & ~r; o.pcen = mr & ~r; end
      S_DECODE: begin o.alusrcb = 2'b11; o.aluctrl = 3'b010; end
      S_MEMADR: begin o.alusrca = 1'b1; o.alusrcb = 2'b10; o.aluctrl = 3'b010; end
      S_MEMRD:  o.iord = 1'b1;
      S_MEMWR:  begin o.iord = 1'b1; o.memwrite = mr; end
      S_MEMWB:  begin o.regwrite = 1'b1; o.memtoreg = 1'b1; end
      S_REX:    begin o.alusrca = 1'b1; o.aluctrl = alu_of(fn); end
      S_RWB:    begin o.regwrite = 1'b1; o.regdst = 1'b1; end
      S_BEQEX:  begin o.alusrca = 1'b1; o.aluctrl = 3'b110; o.pcsrc = 2'b01; o.pcen = z; end
      S_BNEEX:  begin o.alusrca = 1'b1; o.aluctrl = 3'b110; o.pcsrc = 2'b01; o.pcen = ~z; end
      S_ADDIEX: begin o.alusrca = 1'b1; o.alusrcb = 2'b10; o.aluctrl = 3'b010; end
      S_ADDIWB: o.regwrite = 1'b1;
      S_JEX:    begin o.pcsrc = 2'b10; o.pcen = 1'b1; end
      S_ERROR:  o.error = 1'b1;
      default:  o.error = 1'b1;
    endcase
    return o;
  endfunction

  // One clock of stimulus; records what that cycle must show.
  task automatic cyc(input logic r, input logic mr, input state_t s);
    logic z;
    exp_t e;
    @(posedge clk);
    #1;
    z = (z_force >= 0) ? z_force[0] : 1'($urandom_range(0, 1));
    rst = r; mem_ready = mr; zero = z;
    e.v   = ctl_of(s, mr, z, funct, r);
    e.tag = $sformatf("%s@%0d", r ? "RESET" : s.name(), cyc_no);
    cyc_no++;
    sb.push_back(e);
  endtask

  task automatic step(input state_t s);
    cyc(1'b0, 1'($urandom_range(0, 1)), s);
  endtask

  // First reset cycle always sees mem_ready=1 to prove the enables stay masked.
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, (i == 0) ? 1'b1 : 1'($urandom_range(0, 1)), S_FETCH);
  endtask

  task automatic error_tail();
    cyc(1'b0, 1'b1, S_ERROR);
    repeat ($urandom_range(1, 3)) step(S_ERROR);
    do_reset($urandom_range(1, 2));
  endtask

  // Memory step with w not-ready cycles before completion.
  // res: 0 completed, 1 timed out into ERROR, 2 abandoned by reset.
  task automatic mem_step(input state_t s, input int w, input bit ab, output int res);
    res = 0;
    for (int i = 0; i < w && i < TO; i++) cyc(1'b0, 1'b0, s);
    if (w >= TO) begin
      res = 1;
      return;
    end
    if (ab) begin
      do_reset($urandom_range(1, 2));
      res = 2;
      return;
    end
    cyc(1'b0, 1'b1, s);
  endtask

  task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                           input int wf, input int wm, input bit ab);
    int res;
    op = o; funct = f;
    mem_step(S_FETCH, wf, 1'b0, res);
    if (res == 1) begin
      error_tail();
      return;
    end
    step(S_DECODE);
    case (o)
      OP_LW: begin
        step(S_MEMADR);
        mem_step(S_MEMRD, wm, ab, res);
        if (res == 1) error_tail();
        else if (res == 0) step(S_MEMWB);
      end
      OP_SW: begin
        step(S_MEMADR);
        mem_step(S_MEMWR, wm, ab, res);
        if (res == 1) error_tail();
      end
      OP_RTYPE: begin
        step(S_REX);
        if (funct_ok(f)) step(S_RWB);
        else error_tail();
      end
      OP_BEQ:  step(S_BEQEX);
      OP_ADDI: begin step(S_ADDIEX); step(S_ADDIWB); end
      OP_J:    step(S_JEX);
`ifdef MULTICYCLE_BNE_EN
      OP_BNE:  step(S_BNEEX);
`endif
      default: error_tail();
    endcase
  endtask

  function automatic int pick_wait();
    int k;
    k = $urandom_range(0, 9);
    if (k < 6) return 0;
    if (k < 9) return $urandom_range(1, TO - 1);
    return $urandom_range(TO - 1, TO + 1);
  endfunction

  // Monitor: compares one scoreboard entry per falling edge.
  always @(negedge clk) begin
    exp_t e;
    obs_t a;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      a = {iord, irwrite, memwrite, regdst, memtoreg, regwrite, alusrca,
           pcen, error, alusrcb, pcsrc, aluctrl, state};
      n_cmp++;
      if (a !== e.v) begin
        n_bad++;
        $display("FAIL %s: got %b required %b (iord irw mw rd mtr rw asa pcen err asb pcs alu st)",
                 e.tag, a, e.v);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, %0d entries pending", sb.size());
    $fatal(1);
  end

  initial begin
    logic [5:0] valid_fn [5];
    logic [5:0] o, f;
    valid_fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    rst = 1'b1; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;

    do_reset(2);
    // lw, memory always ready: five-cycle walk
    run_instr(OP_LW, 6'b0, 0, 0, 1'b0);
    // sw abandoned by reset in its completing MEMWR cycle
    run_instr(OP_SW, 6'b0, 0, 0, 1'b1);
    run_instr(OP_SW, 6'b0, 0, 0, 1'b0);
    // beq taken then not taken
    z_force = 1; run_instr(OP_BEQ, 6'b0, 0, 0, 1'b0);
    z_force = 0; run_instr(OP_BEQ, 6'b0, 0, 0, 1'b0);
    // bne (option) with both zero values
    z_force = 1; run_instr(OP_BNE, 6'b0, 0, 0, 1'b0);
    z_force = 0; run_instr(OP_BNE, 6'b0, 0, 0, 1'b0);
    z_force = -1;
    // R-type slt and an unsupported funct
    run_instr(OP_RTYPE, 6'b101010, 0, 0, 1'b0);
    run_instr(OP_RTYPE, 6'b000111, 0, 0, 1'b0);
    run_instr(OP_ADDI, 6'b0, 0, 0, 1'b0);
    run_instr(OP_J, 6'b0, 0, 0, 1'b0);
    // timeout boundaries: last allowed wait, then expiry, in each memory state
    run_instr(OP_J, 6'b0, TO - 1, 0, 1'b0);
    run_instr(OP_J, 6'b0, TO, 0, 1'b0);
    run_instr(OP_LW, 6'b0, 0, TO - 1, 1'b0);
    run_instr(OP_LW, 6'b0, 0, TO, 1'b0);
    run_instr(OP_SW, 6'b0, 0, TO, 1'b0);
    run_instr(6'b111111, 6'b0, 0, 0, 1'b0);

    for (int unsigned n = 0; n < 160; n++) begin
      case ($urandom_range(0, 9))
        0, 1:    o = OP_LW;
        2:       o = OP_SW;
        3, 4:    o = OP_RTYPE;
        5:       o = OP_BEQ;
        6:       o = OP_ADDI;
        7:       o = OP_J;
        8:       o = OP_BNE;
        default: o = 6'($urandom);
      endcase
      f = ($urandom_range(0, 4) == 0) ? 6'($urandom) : valid_fn[$urandom_range(0, 4)];
      run_instr(o, f, pick_wait(), pick_wait(), ($urandom_range(0, 24) == 0));
    end

    repeat (2) @(posedge clk);
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard: %0d entries never compared", sb.size());
    end
    if (n_cmp == 0) begin
      n_bad++;
      $display("FAIL monitor: no cycle was compared");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    if (n_bad != 0) $display("*** TEST FAILED ***");
    else            $display("*** TEST PASSED ***");
    $finish;
  end

endmodule

// File: doc/multicycle_fsm.md
MULTICYCLE_FSM -- requirements
Module: multicycle_fsm

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, meaning the maximum number of cycles spent waiting for mem_ready in one memory state.
REQ-002 SHALL have port clk  input  1  system clock, all state on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port op  input  6  instruction bits [31:26] from the instruction register.
REQ-005 SHALL have port funct  input  6  instruction bits [5:0].
REQ-006 SHALL have port zero  input  1  ALU zero flag.
REQ-007 SHALL have port mem_ready  input  1  unified memory has completed the current access this cycle.
REQ-008 SHALL have outputs iord, irwrite, memwrite, regdst, memtoreg, regwrite, alusrca, pcen, error  output  1 each  standard multicycle datapath controls plus a sticky fault flag.
REQ-009 SHALL have outputs alusrcb, pcsrc  output  2 each; aluctrl  output  3; state  output  4 for debug and display.

Function
REQ-010 SHALL implement the states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REX, RWB, BEQEX, ADDIEX, ADDIWB, JEX and ERROR.
REQ-011 In FETCH, SHALL drive iord=0 and alusrca=0, alusrcb=01, pcsrc=00, and aluctrl=010; irwrite and pcen SHALL be 1 only in the cycle mem_ready=1, and the next state SHALL be DECODE.
REQ-012 In DECODE, SHALL drive alusrca=0, alusrcb=11, aluctrl=010, and dispatch on op:
- 100011 or 101011 -> MEMADR
- 000000 -> REX
- 000100 -> BEQEX
- 001000 -> ADDIEX
- 000010 -> JEX
- any other value -> ERROR
REQ-013 MEMADR SHALL drive alusrca=1, alusrcb=10, aluctrl=010, then go to MEMRD for lw or MEMWR for sw.
REQ-014 MEMRD SHALL hold iord=1 until mem_ready, then go to MEMWB; MEMWR SHALL assert iord=1 throughout and memwrite=1 only in its mem_ready cycle, then go to FETCH.
REQ-015 MEMWB SHALL assert regwrite=1, memtoreg=1, regdst=0, then go to FETCH.
REQ-016 REX SHALL drive alusrca=1, alusrcb=00, and aluctrl from funct:
- 100000 -> 010
- 100010 -> 110
- 100100 -> 000
- 100101 -> 001
- 101010 -> 111
- any other funct -> ERROR (the next state after REX SHALL be ERROR instead of RWB)
REQ-017 RWB SHALL assert regwrite=1, regdst=1, memtoreg=0, then go to FETCH.
REQ-018 BEQEX SHALL drive alusrca=1, alusrcb=00, aluctrl=110, pcsrc=01, pcen=zero, then go to FETCH.
REQ-019 ADDIEX SHALL drive alusrca=1, alusrcb=10, aluctrl=010, then go to ADDIWB; ADDIWB SHALL assert regwrite=1, regdst=0, memtoreg=0, then go to FETCH.
REQ-020 JEX SHALL drive pcsrc=10, pcen=1, then go to FETCH.
REQ-021 Every control output not named for a state SHALL be 0 in that state; all outputs SHALL decode combinationally from state, op, funct, zero and mem_ready.
REQ-022 A wait counter SHALL reset on entry to FETCH, MEMRD and MEMWR, and increment each cycle mem_ready=0; reaching MEM_TIMEOUT SHALL force ERROR.
REQ-023 When mem_ready=1 in the same cycle the counter reaches MEM_TIMEOUT, the completed access SHALL win.
REQ-024 ERROR SHALL assert error=1 and hold all write-enables at 0; it SHALL be left only by reset.
REQ-025 Latency SHALL be 3 cycles for j/beq, 4 for R/addi/sw, and 5 for lw, assuming mem_ready=1 on the first cycle of each memory state.

Reset
REQ-026 rst=1 SHALL immediately set state=FETCH, clear the wait counter and error, and force all write-enables (irwrite, memwrite, regwrite, pcen) to 0 while asserted.
REQ-027 Reset asserted mid-instruction SHALL abandon it with no partial register or memory write after release.

Configuration
REQ-028 With macro MULTICYCLE_BNE_EN defined, op 000101 SHALL decode to state BNEEX: as BEQEX but pcen=~zero.
REQ-029 Without MULTICYCLE_BNE_EN, op 000101 SHALL go to ERROR.

Structure
REQ-030 A shared package mc_pkg SHALL hold the state encoding, opcode constants, funct constants and aluctrl codes.
REQ-031 The funct-to-aluctrl decode SHALL be sub-module mc_aludec.

Verification
REQ-032 Reset during MEMWR, mem_ready=1 -> memwrite=0, state=FETCH after release.
REQ-033 lw (op=100011), mem_ready always 1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 only in cycle 5.
REQ-034 beq with zero=1 then zero=0 -> pcen=1, pcsrc=01 in BEQEX; then pcen=0.
REQ-035 FETCH with mem_ready held 0 for 15 cycles -> ERROR, error=1; a later mem_ready=1 leaves state unchanged.
REQ-036 R-type with funct=101010 -> aluctrl=111 in REX; funct=000111 -> ERROR.
REQ-037 op=000101 -> BNEEX with pcen=~zero when MULTICYCLE_BNE_EN is defined; ERROR otherwise.
